// File: rtl/fifo_vc_bank.sv
// Four independent virtual-channel FIFOs with per-VC and aggregate status flags.
// Optional FIFO_VC_OCC_EN exposes the per-VC occupancy counts as an output port.
module fifo_vc_bank #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3,
    parameter int AF_TH  = 6,
    parameter int AE_TH  = 1
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic [1:0]            push_vc,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  pop,
    input  logic [1:0]            pop_vc,
    output logic [DATA_W-1:0]     data_out,
    output logic                  valid_out,
    output logic [3:0]            full,
    output logic [3:0]            empty,
    output logic [3:0]            almost_full_vc,
    output logic [3:0]            almost_empty_vc,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow_err,
`ifdef FIFO_VC_OCC_EN
    output logic [4*(PTR_W+1)-1:0] occupancy,
`endif
    output logic                  underflow_err
);
    localparam int CW = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [4][DEPTH];

    logic [3:0][PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [3:0][PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0][CW-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic pop_acc;
    logic push_acc;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            full[i]            = (cnt_q[i] == CW'(DEPTH));
            empty[i]           = (cnt_q[i] == '0);
            almost_full_vc[i]  = (cnt_q[i] >= CW'(AF_TH));
            almost_empty_vc[i] = (cnt_q[i] <= CW'(AE_TH));
        end
    end

    assign almost_full  = |almost_full_vc;
    assign almost_empty = almost_empty_vc[pop_vc];

    // A full VC still takes a push when the same cycle frees a slot on it.
    assign pop_acc  = pop && !empty[pop_vc];
    assign push_acc = push && (!full[push_vc] ||
                               (pop_acc && (pop_vc == push_vc)));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < 4; i++) begin
            logic inc;
            logic dec;
            inc = push_acc && (push_vc == 2'(i));
            dec = pop_acc && (pop_vc == 2'(i));
            if (inc) wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
            if (dec) rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
            if (inc && !dec) cnt_d[i] = cnt_q[i] + CW'(1);
            if (dec && !inc) cnt_d[i] = cnt_q[i] - CW'(1);
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = pop_acc;
        if (pop_acc) data_d = mem_q[pop_vc][rd_ptr_q[pop_vc]];
        ovf_d = ovf_q | (push && !push_acc);
        unf_d = unf_q | (pop && !pop_acc);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is not reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push_acc) mem_q[push_vc][wr_ptr_q[push_vc]] <= data_in;
    end

    assign data_out      = data_q;
    assign valid_out     = valid_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;
`ifdef FIFO_VC_OCC_EN
    assign occupancy     = cnt_q;
`endif
endmodule
